// File: rtl/soc_result_monitor.sv
// Snoops core data-bus writes to a completion flag and a result word, and times the run.
// FSM: IDLE -> RUN on start, RUN -> DONE on a nonzero flag write, RUN -> TIMEOUT when the watchdog runs out.
module soc_result_monitor #(
  parameter logic [31:0] FLAG_ADDR      = 32'h0000_0100,
  parameter logic [31:0] RESULT_ADDR    = 32'h0000_0104,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] mem_flag_o,
  output logic [31:0] mem_result_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] cycles_o,
  output logic [31:0] last_pc_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_flag, r_result, r_cycles, r_last_pc;
  logic        w_wr, w_flag_hit, w_result_hit, w_unused_addr;
  logic [31:0] w_flag_merged, w_result_merged;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++)
      m[8*k +: 8] = be[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    return m;
  endfunction

  // Word-granular match: the byte offset within the word is irrelevant.
  assign w_wr            = data_req_i & data_we_i;
  assign w_flag_hit      = w_wr & (data_addr_i[31:2] == FLAG_ADDR[31:2]);
  assign w_result_hit    = w_wr & (data_addr_i[31:2] == RESULT_ADDR[31:2]);
  assign w_unused_addr   = ^data_addr_i[1:0];
  assign w_flag_merged   = merge_bytes(r_flag, data_wdata_i, data_be_i);
  assign w_result_merged = merge_bytes(r_result, data_wdata_i, data_be_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) w_next = S_RUN;
        S_RUN: begin
          // A qualifying flag write wins over the watchdog in the same cycle.
          if (w_flag_hit && (w_flag_merged != 32'd0))  w_next = S_DONE;
          else if (r_cycles == TIMEOUT_CYCLES - 32'd1) w_next = S_TIMEOUT;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    done_o    = (r_state == S_DONE);
    timeout_o = (r_state == S_TIMEOUT);
  end

  // Captured values are only touched on run start and during RUN; clear leaves them alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_flag    <= '0;
      r_result  <= '0;
      r_cycles  <= '0;
      r_last_pc <= '0;
    end else if (!clear_i) begin
      if (r_state == S_IDLE && start_i) begin
        r_flag   <= '0;
        r_result <= '0;
        r_cycles <= '0;
      end else if (r_state == S_RUN) begin
        if (w_flag_hit)   r_flag   <= w_flag_merged;
        if (w_result_hit) r_result <= w_result_merged;
        if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
        r_last_pc <= instr_addr_i;
      end
    end
  end

  assign mem_flag_o   = r_flag;
  assign mem_result_o = r_result;
  assign cycles_o     = r_cycles;
  assign last_pc_o    = r_last_pc;

endmodule

// File: tb/tb_soc_result_monitor.sv
// Directed bench for soc_result_monitor: a vector table for single-cycle behaviour plus
// hand-written sequences for nominal completion, timeout, coincidence and async reset.
module tb_soc_result_monitor;

  logic        clk, rst_n, start, clr, req, we;
  logic [31:0] addr, wdata, pc;
  logic [3:0]  be;
  logic [31:0] flag_o, res_o, cyc_o, lpc_o;
  logic        done_o, to_o;

  int errors = 0;
  int checks = 0;

  soc_result_monitor dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clr),
    .data_req_i(req), .data_we_i(we), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_be_i(be), .instr_addr_i(pc),
    .mem_flag_o(flag_o), .mem_result_o(res_o), .done_o(done_o), .timeout_o(to_o),
    .cycles_o(cyc_o), .last_pc_o(lpc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, cl, rq, wr;
    logic [31:0] a, d;
    logic [3:0]  b;
    logic [31:0] p;
    logic [31:0] e_flag, e_res, e_cyc, e_pc;
    logic        e_done, e_to;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, cl, rq, wr, input logic [31:0] a, d,
                     input logic [3:0] b, input logic [31:0] p,
                     input logic [31:0] ef, er, ec, ep, input logic ed, et);
    vec_t v;
    v = '{st, cl, rq, wr, a, d, b, p, ef, er, ec, ep, ed, et};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ef, er, ec, ep,
                         input logic ed, et);
    chk({tag, " flag"},    flag_o, ef);
    chk({tag, " result"},  res_o,  er);
    chk({tag, " cycles"},  cyc_o,  ec);
    chk({tag, " last_pc"}, lpc_o,  ep);
    chk({tag, " done"},    {31'd0, done_o}, {31'd0, ed});
    chk({tag, " timeout"}, {31'd0, to_o},   {31'd0, et});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic bus_wr(input logic [31:0] a, d, input logic [3:0] b);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
  endtask

  task automatic restart();
    clr = 1'b1; step(); clr = 1'b0;
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; pc = '0;
    bus_idle();
    #1;
    chk_all("reset", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    step();

    //   st    cl    rq    we    addr          wdata          be     pc          | flag        result         cyc    last_pc     done  to
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         4'h0, 32'h1000,    32'h0,      32'h0,         32'd0, 32'h0,      1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 32'h104,      32'hAABBCCDD,  4'hF, 32'h1004,    32'h0,      32'hAABBCCDD,  32'd1, 32'h1004,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 32'h104,      32'h11223344,  4'h5, 32'h1008,    32'h0,      32'hAA22CC44,  32'd2, 32'h1008,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 32'h100,      32'h0,         4'hF, 32'h100C,    32'h0,      32'hAA22CC44,  32'd3, 32'h100C,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 32'h106,      32'h7,         4'hF, 32'h1010,    32'h0,      32'h7,         32'd4, 32'h1010,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 32'h100,      32'h5,         4'hF, 32'h1014,    32'h0,      32'h7,         32'd5, 32'h1014,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'h100,      32'h5,         4'hF, 32'h1018,    32'h0,      32'h7,         32'd6, 32'h1018,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 32'h100,      32'h100,       4'h1, 32'h101C,    32'h0,      32'h7,         32'd7, 32'h101C,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 32'h103,      32'h100,       4'h2, 32'h1020,    32'h100,    32'h7,         32'd8, 32'h1020,   1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 32'h104,      32'h99,        4'hF, 32'h1024,    32'h100,    32'h7,         32'd8, 32'h1020,   1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         4'h0, 32'h1028,    32'h100,    32'h7,         32'd8, 32'h1020,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 32'h100,      32'h5,         4'hF, 32'h102C,    32'h100,    32'h7,         32'd8, 32'h1020,   1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         4'h0, 32'h1030,    32'h0,      32'h0,         32'd0, 32'h1020,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         4'h0, 32'h1034,    32'h0,      32'h0,         32'd1, 32'h1034,   1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 32'h108,      32'hDEAD,      4'hF, 32'h1038,    32'h0,      32'h0,         32'd2, 32'h1038,   1'b0, 1'b0);

    foreach (tbl[i]) begin
      start = tbl[i].st; clr = tbl[i].cl; req = tbl[i].rq; we = tbl[i].wr;
      addr = tbl[i].a; wdata = tbl[i].d; be = tbl[i].b; pc = tbl[i].p;
      step();
      chk_all($sformatf("v%0d", i), tbl[i].e_flag, tbl[i].e_res, tbl[i].e_cyc,
              tbl[i].e_pc, tbl[i].e_done, tbl[i].e_to);
    end
    start = 1'b0; clr = 1'b0; bus_idle();

    // Nominal: result at RUN cycle 5, flag=1 at RUN cycle 20.
    restart();
    for (int i = 0; i < 20; i++) begin
      pc = 32'h2000 + 32'(i);
      if (i == 5) bus_wr(32'h104, 32'd55, 4'hF);
      step();
      bus_idle();
    end
    pc = 32'h3000;
    bus_wr(32'h100, 32'd1, 4'hF);
    step();
    bus_idle();
    chk_all("nominal", 32'd1, 32'd55, 32'd21, 32'h3000, 1'b1, 1'b0);
    pc = 32'h4000; start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    chk_all("done_sticky", 32'd1, 32'd55, 32'd21, 32'h3000, 1'b1, 1'b0);

    // Timeout: 100 RUN cycles without a flag write, later writes ignored.
    restart();
    pc = 32'h5000;
    repeat (99) step();
    chk_all("pre_timeout", 32'd0, 32'd0, 32'd99, 32'h5000, 1'b0, 1'b0);
    step();
    chk_all("timeout", 32'd0, 32'd0, 32'd100, 32'h5000, 1'b0, 1'b1);
    bus_wr(32'h100, 32'd1, 4'hF);
    step();
    bus_idle();
    chk_all("timeout_sticky", 32'd0, 32'd0, 32'd100, 32'h5000, 1'b0, 1'b1);

    // Coincidence: qualifying flag write in the cycle with cycles_o == 99.
    restart();
    pc = 32'h6000;
    repeat (99) step();
    bus_wr(32'h100, 32'h0100_0000, 4'h8);
    step();
    bus_idle();
    chk_all("coincide", 32'h0100_0000, 32'd0, 32'd100, 32'h6000, 1'b1, 1'b0);

    // Async reset mid-RUN, then the run must not resume without start.
    restart();
    pc = 32'h7000;
    bus_wr(32'h104, 32'h55, 4'hF);
    step();
    bus_idle();
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) step();
    bus_wr(32'h100, 32'd1, 4'hF);
    step();
    bus_idle();
    chk_all("post_rst_idle", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watch for simultaneous done/timeout throughout the run.
  always @(negedge clk) begin
    if (rst_n && done_o && to_o) begin
      errors++;
      $display("FAIL exclusive: done=%b timeout=%b required not both", done_o, to_o);
    end
  end

endmodule
